fma_dot_lanes: RTL and testbench

Parametrised successor to the single-lane `fma` unit. It computes a LANES-wide signed fixed-point dot product per input beat and accumulates across beats until a beat marked last, then emits one rounded, saturated result. It sits between the operand buffers and the result writeback in the compute core, with a valid/ready handshake on both sides and a 3-stage pipeline.

---
 rtl/fma_dot_lanes.sv | 155 +++++++++++++++
 tb/tb_fma_dot_lanes.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fma_dot_lanes.sv
// Multi-lane signed fixed-point dot product with cross-beat accumulation.
// The result is rounded half-up and then saturated or wrapped.
module fma_dot_lanes #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned FIXED_POINT = 10,
    parameter int unsigned LANES       = 4,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [LANES*WIDTH-1:0] a_in,
    input  logic [LANES*WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0]       c_in,
    input  logic                   valid_in,
    input  logic                   c_load_in,
    input  logic                   last_in,
    output logic                   ready_out,
    output logic [WIDTH-1:0]       out,
    output logic                   overflow_out,
    output logic                   valid_out,
    input  logic                   ready_in
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
    localparam int unsigned ACC_W  = SUM_W + 8;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FIXED_POINT - 1);

    logic stall, adv;

    // Stage 1: lane products
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic [WIDTH-1:0]         c1_q;
    logic                     load1_q, last1_q, v1_q;

    // Stage 2: adder tree
    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic [WIDTH-1:0]        c2_q;
    logic                    load2_q, last2_q, v2_q;

    // Stage 3: accumulator and finished (pre-rounding) result
    logic signed [ACC_W-1:0] acc_q, acc_next, acc_base, c_ext, sum_ext, fin_q;
    logic                    fin_v_q;

    // Output register
    logic signed [ACC_W-1:0] rnd;
    logic                    fits;
    logic [WIDTH-1:0]        res_d, out_q;
    logic                    ovf_q, vout_q;

    assign stall     = vout_q && !ready_in;
    assign adv       = !stall;
    assign ready_out = !stall;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = $signed(a_in[i*WIDTH +: WIDTH]) * $signed(b_in[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
            c1_q    <= '0;
            load1_q <= 1'b0;
            last1_q <= 1'b0;
            v1_q    <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
            c1_q    <= c_in;
            load1_q <= c_load_in;
            last1_q <= last_in;
            v1_q    <= valid_in;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sum_q   <= '0;
            c2_q    <= '0;
            load2_q <= 1'b0;
            last2_q <= 1'b0;
            v2_q    <= 1'b0;
        end else if (adv) begin
            sum_q   <= sum_d;
            c2_q    <= c1_q;
            load2_q <= load1_q;
            last2_q <= last1_q;
            v2_q    <= v1_q;
        end
    end

    always_comb begin
        c_ext    = {{(ACC_W - WIDTH){c2_q[WIDTH-1]}}, c2_q} << FIXED_POINT;
        sum_ext  = {{(ACC_W - SUM_W){sum_q[SUM_W-1]}}, sum_q};
        acc_base = load2_q ? c_ext : acc_q;
        acc_next = acc_base + sum_ext;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q   <= '0;
            fin_q   <= '0;
            fin_v_q <= 1'b0;
        end else if (adv) begin
            if (v2_q) begin
                acc_q   <= last2_q ? '0 : acc_next;
                fin_v_q <= last2_q;
                if (last2_q) fin_q <= acc_next;
            end else begin
                fin_v_q <= 1'b0;
            end
        end
    end

    // Result fits iff every bit from the sign position upward agrees.
    always_comb begin
        rnd  = $signed(fin_q + HALF) >>> FIXED_POINT;
        fits = (&rnd[ACC_W-1:WIDTH-1]) || (~|rnd[ACC_W-1:WIDTH-1]);
        if (SATURATE && !fits) begin
            res_d = rnd[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_d = rnd[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            vout_q <= 1'b0;
        end else if (adv) begin
            if (fin_v_q) begin
                out_q  <= res_d;
                ovf_q  <= !fits;
                vout_q <= 1'b1;
            end else begin
                vout_q <= 1'b0;
            end
        end
    end

    assign out          = out_q;
    assign overflow_out = ovf_q;
    assign valid_out    = vout_q;

endmodule

// File: tb/tb_fma_dot_lanes.sv
// Directed bench for fma_dot_lanes: vector table plus multi-cycle sequences.
// A second instance with SATURATE=0 checks the wrapping behaviour.
module tb_fma_dot_lanes;

    localparam int W = 16;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [L*W-1:0] a_in, b_in;
    logic [W-1:0]   c_in;
    logic           valid_in, c_load_in, last_in, ready_in;
    logic           ready_out, valid_out, overflow_out;
    logic [W-1:0]   out;
    logic           ready_w, valid_w, ovf_w;
    logic [W-1:0]   out_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fma_dot_lanes #(.WIDTH(W), .FIXED_POINT(10), .LANES(L), .SATURATE(1'b1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .valid_in(valid_in), .c_load_in(c_load_in), .last_in(last_in),
        .ready_out(ready_out), .out(out), .overflow_out(overflow_out),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    fma_dot_lanes #(.WIDTH(W), .FIXED_POINT(10), .LANES(L), .SATURATE(1'b0)) dut_w (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .valid_in(valid_in), .c_load_in(c_load_in), .last_in(last_in),
        .ready_out(ready_w), .out(out_w), .overflow_out(ovf_w),
        .valid_out(valid_w), .ready_in(ready_in)
    );

    typedef struct packed {
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [W-1:0]   c;
        logic [W-1:0]   exp_out;
        logic           exp_ovf;
        logic [W-1:0]   exp_out_w;
        logic           exp_ovf_w;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                            input logic [W-1:0] c, input logic cl, input logic lst);
        a_in = a; b_in = b; c_in = c; c_load_in = cl; last_in = lst; valid_in = 1'b1;
    endtask

    task automatic idle();
        a_in = '0; b_in = '0; c_in = '0; c_load_in = 1'b0; last_in = 1'b0; valid_in = 1'b0;
    endtask

    // Watch 10 falling edges; report how many showed valid_out and the last value seen.
    task automatic collect(output logic [W-1:0] o, output logic ov, output int n);
        n = 0; o = '0; ov = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid_out) begin
                n++; o = out; ov = overflow_out;
            end
        end
    endtask

    initial begin
        logic [W-1:0] r_out;
        logic         r_ovf;
        int           n, lat, idx, rcv, stall_left;
        bit           got, first, prev_stall;
        logic [W-1:0] prev_out;
        logic [W-1:0] bp_a [3];
        logic [W-1:0] bp_exp [3];

        //        a (lanes 3..0)                               b (lanes 3..0)
        vecs[0]  = '{{16'h0, 16'h0, 16'h0400, 16'h0800}, {16'h0, 16'h0, 16'hFE00, 16'h0600},
                     16'h0000, 16'h0A00, 1'b0, 16'h0A00, 1'b0};
        vecs[1]  = '{{4{16'h1000}}, {4{16'h1000}}, 16'h0000, 16'h7FFF, 1'b1, 16'h0000, 1'b1};
        vecs[2]  = '{{4{16'hF000}}, {4{16'h1000}}, 16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b1};
        vecs[3]  = '{64'h0001, 64'h0200, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0};
        vecs[4]  = '{64'hFFFF, 64'h0200, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{64'hFFFF, 64'h0400, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vecs[6]  = '{64'h0, 64'h0, 16'h1480, 16'h1480, 1'b0, 16'h1480, 1'b0};
        vecs[7]  = '{64'h1000, 64'h0400, 16'h7000, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
        vecs[8]  = '{64'h03FF, 64'h0400, 16'h7C00, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        vecs[9]  = '{64'h0, 64'h0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0};
        vecs[10] = '{{16'h0400, 16'hFE00, 16'h0, 16'h0}, {16'h0400, 16'h0400, 16'h0, 16'h0},
                     16'h0000, 16'h0200, 1'b0, 16'h0200, 1'b0};

        rst_n = 1'b0; ready_in = 1'b1; idle();
        #1;
        chk("rst_out", out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_valid_w", valid_w, 0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("post_rst_ready", ready_out, 1);

        // Single-beat vectors: latency, saturated and wrapped results
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            set_beat(vecs[v].a, vecs[v].b, vecs[v].c, 1'b1, 1'b1);
            #1 chk($sformatf("v%0d_ready", v), ready_out, 1);
            @(posedge clk);
            #1 idle();
            lat = 0; got = 1'b0;
            while (!got && lat < 10) begin
                @(posedge clk);
                lat++;
                #1 if (valid_out) got = 1'b1;
            end
            chk($sformatf("v%0d_latency", v), lat, 3);
            chk($sformatf("v%0d_out", v), out, vecs[v].exp_out);
            chk($sformatf("v%0d_ovf", v), overflow_out, vecs[v].exp_ovf);
            chk($sformatf("v%0d_valid_w", v), valid_w, 1);
            chk($sformatf("v%0d_out_w", v), out_w, vecs[v].exp_out_w);
            chk($sformatf("v%0d_ovf_w", v), ovf_w, vecs[v].exp_ovf_w);
        end

        // Two-beat accumulate: 1.0 + 2.0*1.5 + 5.125*4.0 = 24.5
        @(negedge clk) set_beat(64'h0800, 64'h0600, 16'h0400, 1'b1, 1'b0);
        @(negedge clk) set_beat(64'h1480, 64'h1000, 16'h0000, 1'b0, 1'b1);
        @(negedge clk) idle();
        collect(r_out, r_ovf, n);
        chk("two_beat_count", n, 1);
        chk("two_beat_out", r_out, 16'h6200);
        chk("two_beat_ovf", r_ovf, 0);

        // Last without a start accumulates onto the cleared accumulator
        @(negedge clk) set_beat(64'h0400, 64'h0400, 16'h0000, 1'b0, 1'b1);
        @(negedge clk) idle();
        collect(r_out, r_ovf, n);
        chk("no_start_count", n, 1);
        chk("no_start_out", r_out, 16'h0400);

        // Backpressure: three back-to-back dots, ready_in low 3 cycles at first result
        bp_a   = '{16'h0400, 16'h0800, 16'h0600};
        bp_exp = '{16'h0400, 16'h0800, 16'h0600};
        idx = 0; rcv = 0; stall_left = 0; first = 1'b0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (valid_out && !first) begin
                first = 1'b1; stall_left = 3;
            end
            ready_in = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (idx < 3) set_beat({48'h0, bp_a[idx]}, 64'h0400, 16'h0000, 1'b1, 1'b1);
            else idle();
            #1;
            if (prev_stall) chk("bp_out_stable", out, prev_out);
            if (valid_out && !ready_in) chk("bp_ready_low", ready_out, 0);
            prev_stall = valid_out && !ready_in;
            prev_out   = out;
            if (valid_out && ready_in) begin
                if (rcv < 3) chk($sformatf("bp_result%0d", rcv), out, bp_exp[rcv]);
                rcv++;
            end
            if (valid_in && ready_out) idx++;
        end
        idle(); ready_in = 1'b1;
        chk("bp_stalled_seen", first, 1);
        chk("bp_beats_sent", idx, 3);
        chk("bp_results", rcv, 3);

        // Reset mid-operation: result held under stall, partial sum in flight
        @(negedge clk);
        ready_in = 1'b0;
        set_beat(64'h0400, 64'h0400, 16'h0000, 1'b1, 1'b1);
        @(negedge clk) set_beat(64'h0800, 64'h0600, 16'h0400, 1'b1, 1'b0);
        @(negedge clk) idle();
        repeat (4) @(negedge clk);
        chk("mid_pre_valid", valid_out, 1);
        chk("mid_pre_out", out, 16'h0400);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_ovf", overflow_out, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_ready", ready_out, 1);
        chk("mid_rst_valid_w", valid_w, 0);
        @(negedge clk);
        rst_n = 1'b1; ready_in = 1'b1;
        #1 chk("mid_release_ready", ready_out, 1);
        collect(r_out, r_ovf, n);
        chk("mid_no_spurious", n, 0);
        // Fresh last-only beat must see a cleared accumulator
        @(negedge clk) set_beat(64'h0600, 64'h0400, 16'h0000, 1'b0, 1'b1);
        @(negedge clk) idle();
        collect(r_out, r_ovf, n);
        chk("mid_fresh_count", n, 1);
        chk("mid_fresh_out", r_out, 16'h0600);
        chk("mid_fresh_ovf", r_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
